mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_rr_arbiter_pkg.sv | 16 +
 rtl/mux_rr_arbiter_rr_pick.sv | 33 +++
 rtl/mux_rr_arbiter.sv | 104 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants for the round-robin word multiplexer: FSM encodings and default geometry.
package mux_rr_arbiter_pkg;

    localparam int DEF_WORD_LEN   = 8;
    localparam int DEF_INPUT_SIZE = 4;
    localparam int DEF_SEL_LEN    = 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Index of the requester that follows idx in a ring of size n.
    function automatic int ring_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin priority search: first eligible request above last_grant, with wrap.
module rr_pick
    import mux_rr_arbiter_pkg::*;
#(
    parameter int INPUT_SIZE = DEF_INPUT_SIZE,
    parameter int SEL_LEN    = DEF_SEL_LEN
) (
    input  logic [INPUT_SIZE-1:0] req,
    input  logic [SEL_LEN-1:0]    last_grant,
    input  logic [INPUT_SIZE-1:0] eligible,
    output logic [SEL_LEN-1:0]    grant_idx,
    output logic                  grant_any
);

    logic [INPUT_SIZE-1:0] masked;
    int                    idx;

    assign masked = req & eligible;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = int'(last_grant);
        for (int k = 0; k < INPUT_SIZE; k++) begin
            idx = ring_next(idx, INPUT_SIZE);
            if (!grant_any && masked[idx]) begin
                grant_any = 1'b1;
                grant_idx = SEL_LEN'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin N:1 word multiplexer with a registered output slot and ready/ack handshake.
// Optional grant lock (sticky re-grant of the last winner) enabled by defining MUX_ARB_LOCK_EN.
//
// state | meaning
// IDLE  | no word held; arbitrate over req each cycle
// BUSY  | granted word held in out_data until out_ready
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WORD_LEN   = DEF_WORD_LEN,
    parameter int INPUT_SIZE = DEF_INPUT_SIZE,
    parameter int SEL_LEN    = DEF_SEL_LEN
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [INPUT_SIZE-1:0]          req,
    input  logic [WORD_LEN*INPUT_SIZE-1:0] in_data,
`ifdef MUX_ARB_LOCK_EN
    input  logic [INPUT_SIZE-1:0]          lock,
`endif
    output logic [INPUT_SIZE-1:0]          ack,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WORD_LEN-1:0]            out_data,
    output logic [SEL_LEN-1:0]             out_sel
);

    logic [0:0]            state;
    logic [SEL_LEN-1:0]    last_grant;
    logic [SEL_LEN-1:0]    grant_idx;
    logic                  grant_any;
    logic                  locked;
    logic                  handshake;
    logic [INPUT_SIZE-1:0] eligible;
    logic [WORD_LEN-1:0]   words [INPUT_SIZE];

    // Requester 0 occupies the most significant word of in_data.
    for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_unpack
        assign words[i] = in_data[WORD_LEN*(INPUT_SIZE-1-i) +: WORD_LEN];
    end

    assign handshake = (state == ST_BUSY) && out_valid && out_ready;
    assign ack       = handshake ? (INPUT_SIZE'(1) << out_sel) : '0;
    assign eligible  = locked ? (INPUT_SIZE'(1) << last_grant) : '1;

    rr_pick #(
        .INPUT_SIZE (INPUT_SIZE),
        .SEL_LEN    (SEL_LEN)
    ) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .eligible   (eligible),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            last_grant <= SEL_LEN'(INPUT_SIZE - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        out_data  <= words[grant_idx];
                        out_sel   <= grant_idx;
                        out_valid <= 1'b1;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (handshake) begin
                        last_grant <= out_sel;
                        out_valid  <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MUX_ARB_LOCK_EN
    // A lock that the holder has stopped requesting is released so the ring can move on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked <= 1'b0;
        end else if (handshake) begin
            locked <= lock[out_sel];
        end else if (state == ST_IDLE && !req[last_grant]) begin
            locked <= 1'b0;
        end
    end
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized and directed bench for mux_rr_arbiter against a cycle-level behavioural model.
module tb_mux_rr_arbiter;

    localparam int W = 8;
    localparam int N = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [W*N-1:0] in_data;
    logic [N-1:0]   ack;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [S-1:0]   out_sel;
    logic [N-1:0]   lock_val;

    int vectors = 0;
    int errors  = 0;

    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    int           m_last;
    bit           m_locked;

    always #5 clk = ~clk;

`ifdef MUX_ARB_LOCK_EN
    logic [N-1:0] lock;
    assign lock = lock_val;
`endif

    mux_rr_arbiter #(.WORD_LEN(W), .INPUT_SIZE(N), .SEL_LEN(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_data   (in_data),
`ifdef MUX_ARB_LOCK_EN
        .lock      (lock),
`endif
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    function automatic logic [W-1:0] word_of(input logic [W*N-1:0] d, input int p);
        return W'(d >> (W * (N - 1 - p)));
    endfunction

    function automatic int ref_pick(input logic [N-1:0] r, input int last, input bit lk);
        int i;
        if (lk) return r[last] ? last : -1;
        for (int k = 1; k <= N; k++) begin
            i = (last + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ack();
        return (m_valid && out_ready) ? (N'(1) << m_sel) : '0;
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = '0;
        m_sel    = 0;
        m_last   = N - 1;
        m_locked = 1'b0;
    endtask

    task automatic model_edge();
        int p;
        if (m_valid) begin
            if (out_ready) begin
                m_last   = m_sel;
                m_valid  = 1'b0;
                m_locked = lock_val[m_sel];
            end
        end else begin
            p = ref_pick(req, m_last, m_locked);
            if (m_locked && !req[m_last]) m_locked = 1'b0;
            if (p >= 0) begin
                m_valid = 1'b1;
                m_sel   = p;
                m_data  = word_of(in_data, p);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        req       = '0;
        lock_val  = '0;
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b1;
        in_data   = 32'hA1B2C3D4;
        lock_val  = '0;
        model_reset();
        #2;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0 || ack !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h sel=%0d ack=%b, want 0 00 0 0000",
                     out_valid, out_data, out_sel, ack);
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        int hs_sel[$];
        int hs_cyc[$];
        logic [W-1:0] hs_dat[$];
        int exp_sel [5];
        logic [W-1:0] exp_dat [5];
        exp_sel = '{0, 1, 2, 3, 0};
        exp_dat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA};
        do_reset();
        in_data   = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            #1;
            vectors++;
            if (ack !== exp_ack() || out_valid !== m_valid ||
                (m_valid && (out_data !== m_data || out_sel !== S'(m_sel)))) begin
                errors++;
                $display("FAIL rr_cycle %0d: ack=%b valid=%b data=%h sel=%0d, want ack=%b valid=%b data=%h sel=%0d",
                         c, ack, out_valid, out_data, out_sel, exp_ack(), m_valid, m_data, m_sel);
            end
            if (m_valid && out_ready) begin
                hs_sel.push_back(m_sel);
                hs_dat.push_back(m_data);
                hs_cyc.push_back(c);
            end
            tick();
        end
        vectors++;
        if (hs_sel.size() < 5) begin
            errors++;
            $display("FAIL rr_count: got %0d handshakes, want 5", hs_sel.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (hs_sel[i] != exp_sel[i] || hs_dat[i] !== exp_dat[i]) begin
                    errors++;
                    $display("FAIL rr_order %0d: sel=%0d data=%h, want sel=%0d data=%h",
                             i, hs_sel[i], hs_dat[i], exp_sel[i], exp_dat[i]);
                end
                if (i > 0) begin
                    vectors++;
                    if (hs_cyc[i] - hs_cyc[i-1] != 2) begin
                        errors++;
                        $display("FAIL rr_rate %0d: spacing=%0d, want 2", i, hs_cyc[i] - hs_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_data   = {8'h11, 8'h22, 8'h5C, 8'h44};
        req       = 4'b0100;
        out_ready = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'h5C) begin
            errors++;
            $display("FAIL bp_grant: valid=%b sel=%0d data=%h, want 1 2 5c", out_valid, out_sel, out_data);
        end
        for (int c = 0; c < 5; c++) begin
            if (c == 2) in_data[15:8] = 8'hE7;
            req = (c == 3) ? 4'b1011 : 4'b0100;
            #1;
            vectors++;
            if (out_data !== 8'h5C || out_sel !== 2'd2 || ack !== 4'b0000 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold %0d: data=%h sel=%0d ack=%b valid=%b, want 5c 2 0000 1",
                         c, out_data, out_sel, ack, out_valid);
            end
            tick();
        end
        req       = 4'b0100;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (ack !== 4'b0100) begin
            errors++;
            $display("FAIL bp_ack: ack=%b, want 0100", ack);
        end
        tick();
        req = 4'b0000;
        #1;
        vectors++;
        if (ack !== 4'b0000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_ack_once: ack=%b valid=%b, want 0000 0", ack, out_valid);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        in_data   = 32'h01020304;
        req       = 4'b1000;
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_sel !== 2'd3) begin
            errors++;
            $display("FAIL wrap_setup: valid=%b sel=%0d, want 1 3", out_valid, out_sel);
        end
        tick();
        req = 4'b1001;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'h01) begin
            errors++;
            $display("FAIL wrap_to_0: valid=%b sel=%0d data=%h, want 1 0 01", out_valid, out_sel, out_data);
        end
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 8'h04) begin
            errors++;
            $display("FAIL wrap_next_3: valid=%b sel=%0d data=%h, want 1 3 04", out_valid, out_sel, out_data);
        end
        tick();
    endtask

    task automatic test_reset_busy();
        do_reset();
        in_data   = 32'h10203040;
        req       = 4'b0100;
        out_ready = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstbusy_setup: valid=%b, want 1", out_valid);
        end
        out_ready = 1'b1;
        rst_n     = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (out_valid !== 1'b0 || ack !== 4'b0000) begin
            errors++;
            $display("FAIL rstbusy_drop: valid=%b ack=%b, want 0 0000", out_valid, ack);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'h10) begin
            errors++;
            $display("FAIL rstbusy_regrant: valid=%b sel=%0d data=%h, want 1 0 10", out_valid, out_sel, out_data);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req       = N'($urandom) & N'($urandom | (c % 3 == 0 ? 32'hF : 32'h0));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_ARB_LOCK_EN
            lock_val  = N'($urandom);
`endif
            #1;
            vectors++;
            if (ack !== exp_ack() || out_valid !== m_valid ||
                (m_valid && (out_data !== m_data || out_sel !== S'(m_sel)))) begin
                errors++;
                $display("FAIL rand_cycle %0d: ack=%b valid=%b data=%h sel=%0d, want ack=%b valid=%b data=%h sel=%0d",
                         c, ack, out_valid, out_data, out_sel, exp_ack(), m_valid, m_data, m_sel);
            end
            tick();
        end
        lock_val = '0;
    endtask

`ifdef MUX_ARB_LOCK_EN
    task automatic test_lock();
        int grants[$];
        int n1;
        int exp_g [5];
        exp_g = '{0, 1, 1, 1, 0};
        n1 = 0;
        do_reset();
        in_data   = 32'hA0B0C0D0;
        req       = 4'b0011;
        out_ready = 1'b1;
        for (int c = 0; c < 14 && grants.size() < 5; c++) begin
            lock_val = (n1 < 2) ? 4'b0010 : 4'b0000;
            #1;
            vectors++;
            if (ack !== exp_ack() || out_valid !== m_valid ||
                (m_valid && (out_data !== m_data || out_sel !== S'(m_sel)))) begin
                errors++;
                $display("FAIL lock_cycle %0d: ack=%b valid=%b sel=%0d, want ack=%b valid=%b sel=%0d",
                         c, ack, out_valid, out_sel, exp_ack(), m_valid, m_sel);
            end
            if (out_valid === 1'b1 && out_ready) begin
                grants.push_back(int'(out_sel));
                if (out_sel == 2'd1) n1++;
            end
            tick();
        end
        vectors++;
        if (grants.size() != 5) begin
            errors++;
            $display("FAIL lock_count: got %0d grants, want 5", grants.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (grants[i] != exp_g[i]) begin
                    errors++;
                    $display("FAIL lock_order %0d: sel=%0d, want %0d", i, grants[i], exp_g[i]);
                end
            end
        end
        lock_val = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_busy();
`ifdef MUX_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
